// File: rtl/hdma_engine_pkg.sv
// Shared types for the block-DMA (HDMA) engine:
// FSM states, register selects and the address decode helper.
package hdma_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HB_WAIT,
    READ,
    WRITE
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SRC_HI,
    SEL_SRC_LO,
    SEL_DST_HI,
    SEL_DST_LO,
    SEL_CTRL
  } sel_t;

  localparam int MODE_BIT = 7;

  function automatic sel_t reg_decode(
    input logic [15:0] addr,
    input logic [15:0] base
  );
    logic [15:0] off;
    off = addr - base;
    case (off)
      16'd0:   return SEL_SRC_HI;
      16'd1:   return SEL_SRC_LO;
      16'd2:   return SEL_DST_HI;
      16'd3:   return SEL_DST_LO;
      16'd4:   return SEL_CTRL;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hdma_engine_if.sv
// Strobe and status bundle between the HDMA engine
// and the CPU/PPU side of the shared bus.
interface hdma_engine_if;
  logic mem_re;
  logic mem_we;
  logic hblank;
  logic dma_mem_re;
  logic dma_mem_we;
  logic cpu_mem_disable;
  logic hdma_active;

  modport master (
    input  mem_re, mem_we, hblank,
    output dma_mem_re, dma_mem_we,
    output cpu_mem_disable, hdma_active
  );

  modport slave (
    output mem_re, mem_we, hblank,
    input  dma_mem_re, dma_mem_we,
    input  cpu_mem_disable, hdma_active
  );
endinterface

// File: rtl/hdma_engine_regs.sv
// HDMA register file: decode, src/dst pointers, block counter, status.
// HDMA_READBACK_EN makes HDMA1-4 readable as live pointers.
module hdma_engine_regs
  import hdma_engine_pkg::*;
#(
  parameter int          BLOCK_BYTES = 16,
  parameter logic [15:0] REG_BASE    = 16'hFF51,
  parameter logic [15:0] DEST_BASE   = 16'h8000,
  parameter int          DEST_BITS   = 13
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        re_en,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        active,
  input  logic        arm,
  input  logic        cancel,
  input  logic        step,
  output logic [15:0] src,
  output logic [15:0] dst_addr,
  output logic [7:0]  rdata,
  output logic        rd_hit,
  output logic        ctrl_wr,
  output logic        block_end,
  output logic        last_block
);

  localparam int OFF = $clog2(BLOCK_BYTES);
  localparam logic [7:0] LO_MASK = 8'(8'hFF << OFF);

  logic [DEST_BITS-1:0] dst;
  logic [6:0]           rem;
  logic                 cancelled;
  logic [7:0]           status;
  sel_t                 sel;

  assign sel        = reg_decode(addr, REG_BASE);
  assign ctrl_wr    = wr_en && sel == SEL_CTRL;
  assign dst_addr   = DEST_BASE | 16'(dst);
  assign block_end  = &dst[OFF-1:0];
  assign last_block = rem == '0;

  assign status = active    ? {1'b0, rem} :
                  cancelled ? {1'b1, rem} :
                              8'hFF;

  // Pointer writes (locked while armed), stepping, block count, cancel flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src       <= '0;
      dst       <= '0;
      rem       <= '0;
      cancelled <= 1'b0;
    end else begin
      if (wr_en && !active) begin
        unique case (sel)
          SEL_SRC_HI: src[15:8] <= wdata;
          SEL_SRC_LO: src[7:0]  <= wdata & LO_MASK;
          SEL_DST_HI: dst[DEST_BITS-1:8] <= wdata[DEST_BITS-9:0];
          SEL_DST_LO: dst[7:0]  <= wdata & LO_MASK;
          default: ;
        endcase
      end
      if (step) begin
        src <= src + 16'd1;
        dst <= dst + DEST_BITS'(1);
        if (block_end && !last_block)
          rem <= rem - 7'd1;
      end
      if (arm) begin
        rem       <= wdata[6:0];
        cancelled <= 1'b0;
      end
      if (cancel)
        cancelled <= 1'b1;
    end
  end

`ifdef HDMA_READBACK_EN
  // Read mux: live pointers on HDMA1-4, status on HDMA5.
  always_comb begin
    rdata  = status;
    rd_hit = re_en && sel != SEL_NONE;
    unique case (sel)
      SEL_SRC_HI: rdata = src[15:8];
      SEL_SRC_LO: rdata = src[7:0];
      SEL_DST_HI: rdata = dst_addr[15:8];
      SEL_DST_LO: rdata = dst_addr[7:0];
      default: ;
    endcase
  end
`else
  assign rd_hit = re_en && sel == SEL_CTRL;
  assign rdata  = status;
`endif

endmodule

// File: rtl/hdma_engine.sv
// CGB-style HDMA: block copies from any source into the VRAM window.
// Build option HDMA_READBACK_EN: HDMA1-4 read back live pointers.
module hdma_engine
  import hdma_engine_pkg::*;
#(
  parameter int          BLOCK_BYTES = 16,
  parameter logic [15:0] REG_BASE    = 16'hFF51,
  parameter logic [15:0] DEST_BASE   = 16'h8000,
  parameter int          DEST_BITS   = 13
) (
  input  logic         clock,
  input  logic         reset,
  inout  wire  [15:0]  addr_ext,
  inout  wire  [7:0]   data_ext,
  hdma_engine_if.master bus
);

  state_t      state;
  logic        mode;
  logic        hb_prev;
  logic [7:0]  temp;
  logic [15:0] src;
  logic [15:0] dst_addr;
  logic [7:0]  rdata;
  logic        rd_hit;
  logic        ctrl_wr;
  logic        block_end;
  logic        last_block;
  logic        xfer;
  logic        arm;
  logic        cancel;

  assign xfer   = state == READ || state == WRITE;
  assign arm    = ctrl_wr && state == IDLE;
  assign cancel = ctrl_wr && state == HB_WAIT
               && !data_ext[MODE_BIT];

  hdma_engine_regs #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .REG_BASE    (REG_BASE),
    .DEST_BASE   (DEST_BASE),
    .DEST_BITS   (DEST_BITS)
  ) u_regs (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (bus.mem_we && !xfer),
    .re_en      (bus.mem_re && !xfer),
    .addr       (addr_ext),
    .wdata      (data_ext),
    .active     (bus.hdma_active),
    .arm        (arm),
    .cancel     (cancel),
    .step       (state == WRITE),
    .src        (src),
    .dst_addr   (dst_addr),
    .rdata      (rdata),
    .rd_hit     (rd_hit),
    .ctrl_wr    (ctrl_wr),
    .block_end  (block_end),
    .last_block (last_block)
  );

  assign bus.dma_mem_re      = state == READ;
  assign bus.dma_mem_we      = state == WRITE;
  assign bus.cpu_mem_disable = xfer;
  assign bus.hdma_active     = state != IDLE;

  assign addr_ext = state == READ  ? src      :
                    state == WRITE ? dst_addr :
                                     16'hzzzz;

  assign data_ext = state == WRITE ? temp  :
                    rd_hit         ? rdata :
                                     8'hzz;

  // Sequencer: one READ and one WRITE per byte; H-blank mode waits per block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mode    <= 1'b0;
      hb_prev <= 1'b0;
      temp    <= '0;
    end else begin
      hb_prev <= arm ? 1'b0 : bus.hblank;
      unique case (state)
        IDLE: begin
          if (arm) begin
            mode  <= data_ext[MODE_BIT];
            state <= data_ext[MODE_BIT] ? HB_WAIT : READ;
          end
        end
        HB_WAIT: begin
          if (cancel)
            state <= IDLE;
          else if (bus.hblank && !hb_prev)
            state <= READ;
        end
        READ: begin
          temp  <= data_ext;
          state <= WRITE;
        end
        WRITE: begin
          if (!block_end)
            state <= READ;
          else if (last_block)
            state <= IDLE;
          else if (mode)
            state <= HB_WAIT;
          else
            state <= READ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdma_engine.sv
// Randomized bench for hdma_engine: copies compared against a
// byte-level source/destination model with wrap arithmetic.
module tb_hdma_engine;

  localparam logic [15:0] H1 = 16'hFF51;
  localparam logic [15:0] H2 = 16'hFF52;
  localparam logic [15:0] H3 = 16'hFF53;
  localparam logic [15:0] H4 = 16'hFF54;
  localparam logic [15:0] H5 = 16'hFF55;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wire [15:0] addr_ext;
  wire [7:0]  data_ext;
  hdma_engine_if bus ();

  logic        cpu_aoe = 1'b0;
  logic        cpu_doe = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;

  logic [7:0] smem [0:65535];
  logic [7:0] wmem [0:65535];
  int wcount = 0;
  int errors = 0;
  int checks = 0;

  logic [15:0] m_src;
  logic [12:0] m_dst;

  assign addr_ext = cpu_aoe ? cpu_addr : 16'hzzzz;
  assign data_ext = cpu_doe        ? cpu_wdata       :
                    bus.dma_mem_re ? smem[addr_ext]  :
                                     8'hzz;

  always @(posedge clock) begin
    if (bus.dma_mem_we) begin
      wmem[addr_ext] <= data_ext;
      wcount <= wcount + 1;
    end
  end

  hdma_engine dut (
    .clock    (clock),
    .reset    (reset),
    .addr_ext (addr_ext),
    .data_ext (data_ext),
    .bus      (bus.master)
  );

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    cpu_aoe = 1'b1; cpu_addr = a;
    cpu_doe = 1'b1; cpu_wdata = d;
    bus.mem_we = 1'b1;
    @(posedge clock); #1;
    cpu_aoe = 1'b0; cpu_doe = 1'b0;
    bus.mem_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    cpu_aoe = 1'b1; cpu_addr = a;
    bus.mem_re = 1'b1;
    #1 d = data_ext;
    @(posedge clock); #1;
    cpu_aoe = 1'b0;
    bus.mem_re = 1'b0;
  endtask

  task automatic set_ptrs(input logic [15:0] s, input logic [15:0] d);
    cpu_write(H1, s[15:8]);
    cpu_write(H2, s[7:0]);
    cpu_write(H3, d[15:8]);
    cpu_write(H4, d[7:0]);
    m_src = s & 16'hFFF0;
    m_dst = 13'(d) & 13'h1FF0;
  endtask

  task automatic fill(input logic [15:0] s, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = s + 16'(i);
      smem[a] = 8'($urandom);
    end
  endtask

  task automatic advance(input int n);
    m_src = m_src + 16'(n);
    m_dst = m_dst + 13'(n);
  endtask

  function automatic int copy_bad(input logic [15:0] s,
                                  input logic [12:0] d,
                                  input int n);
    int bad;
    logic [15:0] sa;
    logic [15:0] da;
    logic [12:0] off;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      sa  = s + 16'(i);
      off = d + 13'(i);
      da  = 16'h8000 | {3'b000, off};
      if (wmem[da] !== smem[sa]) bad++;
    end
    return bad;
  endfunction

  task automatic measure(input int budget, output int busy);
    int i;
    bit done;
    i = 0; busy = 0; done = 1'b0;
    while (!done && i < budget) begin
      @(negedge clock);
      i++;
      if (bus.cpu_mem_disable) busy++;
      if (!bus.hdma_active) done = 1'b1;
    end
    if (!done) busy = -1;
  endtask

  task automatic hblank_pulse(output int busy);
    busy = 0;
    @(negedge clock);
    bus.hblank = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (bus.cpu_mem_disable) busy++;
    end
    bus.hblank = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [3:0] outs;
    logic [7:0] rd;
    outs = {bus.dma_mem_re, bus.dma_mem_we,
            bus.cpu_mem_disable, bus.hdma_active};
    checks++;
    if (outs !== 4'b0) begin
      errors++;
      $display("FAIL reset_outs got=%b want=0000", outs);
    end
    cpu_read(H5, rd);
    checks++;
    if (rd !== 8'hFF) begin
      errors++;
      $display("FAIL reset_hdma5 got=%h want=ff", rd);
    end
  endtask

  task automatic test_general();
    int busy, w0, bad, n, len;
    logic [7:0] rd;
    set_ptrs(16'hC000, 16'h8000);
    fill(m_src, 16);
    w0 = wcount;
    cpu_write(H5, 8'h00);
    measure(200, busy);
    checks++;
    if (busy !== 32) begin
      errors++;
      $display("FAIL gen_latency got=%0d want=32", busy);
    end
    checks++;
    if (wcount - w0 !== 16) begin
      errors++;
      $display("FAIL gen_writes got=%0d want=16", wcount - w0);
    end
    bad = copy_bad(m_src, m_dst, 16);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gen_copy bad=%0d want=0", bad);
    end
    cpu_read(H5, rd);
    checks++;
    if (rd !== 8'hFF) begin
      errors++;
      $display("FAIL gen_hdma5 got=%h want=ff", rd);
    end
    for (int k = 0; k < 3; k++) begin
      set_ptrs(16'($urandom), 16'($urandom));
      len = int'($urandom_range(0, 3));
      n = 16 * (len + 1);
      fill(m_src, n);
      w0 = wcount;
      cpu_write(H5, 8'(len));
      measure(2 * n + 20, busy);
      checks++;
      if (busy !== 2 * n) begin
        errors++;
        $display("FAIL rnd_latency got=%0d want=%0d", busy, 2 * n);
      end
      checks++;
      if (wcount - w0 !== n) begin
        errors++;
        $display("FAIL rnd_writes got=%0d want=%0d", wcount - w0, n);
      end
      bad = copy_bad(m_src, m_dst, n);
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rnd_copy bad=%0d want=0", bad);
      end
    end
  endtask

  task automatic test_hblank();
    int busy, w0, bad;
    logic [7:0] rd, exp;
    set_ptrs(16'($urandom), 16'($urandom));
    fill(m_src, 48);
    cpu_write(H5, 8'h82);
    cpu_read(H5, rd);
    checks++;
    if (rd !== 8'h02) begin
      errors++;
      $display("FAIL hb_armed got=%h want=02", rd);
    end
    for (int b = 0; b < 3; b++) begin
      w0 = wcount;
      hblank_pulse(busy);
      checks++;
      if (busy !== 32) begin
        errors++;
        $display("FAIL hb_busy blk=%0d got=%0d want=32", b, busy);
      end
      checks++;
      if (wcount - w0 !== 16) begin
        errors++;
        $display("FAIL hb_writes got=%0d want=16", wcount - w0);
      end
      checks++;
      if (bus.cpu_mem_disable !== 1'b0) begin
        errors++;
        $display("FAIL hb_cpu_free got=%b want=0", bus.cpu_mem_disable);
      end
      exp = (b == 2) ? 8'hFF : 8'(1 - b);
      cpu_read(H5, rd);
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL hb_hdma5 got=%h want=%h", rd, exp);
      end
    end
    bad = copy_bad(m_src, m_dst, 48);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hb_copy bad=%0d want=0", bad);
    end
  endtask

  task automatic test_cancel();
    int busy, b2, w0, bad;
    logic [7:0] rd;
    set_ptrs(16'($urandom), 16'($urandom));
    fill(m_src, 32);
    cpu_write(H5, 8'h83);
    hblank_pulse(busy);
    checks++;
    if (busy !== 32) begin
      errors++;
      $display("FAIL cx_first got=%0d want=32", busy);
    end
    cpu_write(H5, 8'h00);
    cpu_read(H5, rd);
    checks++;
    if (rd !== 8'h82) begin
      errors++;
      $display("FAIL cx_hdma5 got=%h want=82", rd);
    end
    checks++;
    if (bus.hdma_active !== 1'b0) begin
      errors++;
      $display("FAIL cx_active got=%b want=0", bus.hdma_active);
    end
    w0 = wcount;
    hblank_pulse(busy);
    hblank_pulse(b2);
    checks++;
    if (wcount - w0 + busy + b2 !== 0) begin
      errors++;
      $display("FAIL cx_quiet got=%0d want=0", wcount - w0 + busy + b2);
    end
    bad = copy_bad(m_src, m_dst, 16);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL cx_copy bad=%0d want=0", bad);
    end
    advance(16);
    cpu_write(H5, 8'h00);
    measure(100, busy);
    bad = copy_bad(m_src, m_dst, 16);
    checks++;
    if (busy !== 32 || bad !== 0) begin
      errors++;
      $display("FAIL cx_resume busy=%0d bad=%0d want=32/0", busy, bad);
    end
  endtask

  task automatic test_wrap();
    int busy, bad;
    set_ptrs(16'hFFF0, 16'h9FF0);
    fill(m_src, 32);
    cpu_write(H5, 8'h01);
    measure(200, busy);
    checks++;
    if (busy !== 64) begin
      errors++;
      $display("FAIL wrap_latency got=%0d want=64", busy);
    end
    bad = copy_bad(m_src, m_dst, 32);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wrap_copy bad=%0d want=0", bad);
    end
    checks++;
    if (wmem[16'h8000] !== smem[16'h0000]) begin
      errors++;
      $display("FAIL wrap_8000 got=%h want=%h",
               wmem[16'h8000], smem[16'h0000]);
    end
  endtask

  task automatic test_reset_mid();
    int busy, bad;
    logic [3:0] outs;
    logic [7:0] rd;
    set_ptrs(16'($urandom), 16'($urandom));
    fill(m_src, 32);
    cpu_write(H5, 8'h01);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    outs = {bus.dma_mem_re, bus.dma_mem_we,
            bus.cpu_mem_disable, bus.hdma_active};
    checks++;
    if (outs !== 4'b0) begin
      errors++;
      $display("FAIL rmid_outs got=%b want=0000", outs);
    end
    @(negedge clock);
    reset = 1'b0;
    cpu_read(H5, rd);
    checks++;
    if (rd !== 8'hFF) begin
      errors++;
      $display("FAIL rmid_hdma5 got=%h want=ff", rd);
    end
`ifdef HDMA_READBACK_EN
    cpu_read(H2, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL rmid_src got=%h want=00", rd);
    end
`endif
    set_ptrs(16'($urandom), 16'($urandom));
    fill(m_src, 16);
    cpu_write(H5, 8'h00);
    measure(100, busy);
    bad = copy_bad(m_src, m_dst, 16);
    checks++;
    if (busy !== 32 || bad !== 0) begin
      errors++;
      $display("FAIL rmid_after busy=%0d bad=%0d want=32/0", busy, bad);
    end
  endtask

  task automatic test_ignore();
    int busy, bad;
    logic [7:0] rd;
`ifdef HDMA_READBACK_EN
    logic [15:0] full;
`endif
    set_ptrs(16'($urandom), 16'($urandom));
    fill(m_src, 16);
    cpu_write(H5, 8'h80);
    cpu_write(H1, 8'($urandom));
    cpu_write(H2, 8'($urandom));
    cpu_write(H3, 8'($urandom));
    cpu_write(H4, 8'($urandom));
`ifdef HDMA_READBACK_EN
    full = 16'h8000 | {3'b000, m_dst};
    cpu_read(H1, rd);
    checks++;
    if (rd !== m_src[15:8]) begin
      errors++;
      $display("FAIL ign_h1 got=%h want=%h", rd, m_src[15:8]);
    end
    cpu_read(H3, rd);
    checks++;
    if (rd !== full[15:8]) begin
      errors++;
      $display("FAIL ign_h3 got=%h want=%h", rd, full[15:8]);
    end
`endif
    hblank_pulse(busy);
    bad = copy_bad(m_src, m_dst, 16);
    checks++;
    if (busy !== 32 || bad !== 0) begin
      errors++;
      $display("FAIL ign_copy busy=%0d bad=%0d want=32/0", busy, bad);
    end
    advance(16);
    cpu_read(H5, rd);
    checks++;
    if (rd !== 8'hFF) begin
      errors++;
      $display("FAIL ign_hdma5 got=%h want=ff", rd);
    end
`ifdef HDMA_READBACK_EN
    full = 16'h8000 | {3'b000, m_dst};
    cpu_read(H4, rd);
    checks++;
    if (rd !== full[7:0]) begin
      errors++;
      $display("FAIL ign_h4 got=%h want=%h", rd, full[7:0]);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_re = 1'b0;
    bus.mem_we = 1'b0;
    bus.hblank = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_general();
    test_hblank();
    test_cancel();
    test_wrap();
    test_reset_mid();
    test_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
